csa_accum_ctrl: RTL and testbench



---
 rtl/csa_accum_ctrl_if.sv | 39 +++
 rtl/csa_accum_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_csa_accum_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/csa_accum_ctrl_if.sv
// Handshake bundle for csa_accum_ctrl: job start, beat input and result output.
// CSA_ACCUM_STALL_CNT_EN adds the stall_cnt observation signal.
interface csa_accum_ctrl_if #(
    parameter int MAX_BEATS = 16,
    parameter int CNT_W     = $clog2(MAX_BEATS + 1)
);
    logic                  start;
    logic [CNT_W-1:0]      num_beats;
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0][18:0]      in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [18:0]           out_sum;
    logic                  busy;
`ifdef CSA_ACCUM_STALL_CNT_EN
    logic [15:0]           stall_cnt;

    modport master (
        output start, num_beats, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, busy, stall_cnt
    );

    modport slave (
        input  start, num_beats, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, busy, stall_cnt
    );
`else
    modport master (
        output start, num_beats, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, busy
    );

    modport slave (
        input  start, num_beats, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, busy
    );
`endif
endinterface

// File: rtl/csa_accum_ctrl.sv
// Multi-beat carry-save accumulator sharing one 6:2 compressor, with a final resolve add.
// Optional macro CSA_ACCUM_STALL_CNT_EN adds a saturating ACCUM stall counter.

module add_16_6 (
    input  logic [18:0] in0,
    input  logic [18:0] in1,
    input  logic [18:0] in2,
    input  logic [18:0] in3,
    input  logic [18:0] in4,
    input  logic [18:0] in5,
    output logic [18:0] c,
    output logic [18:0] s
);
    // One 3:2 row: {carry shifted left by one (bit 18 carry dropped), sum}
    function automatic logic [37:0] csa32(input logic [18:0] a,
                                          input logic [18:0] b,
                                          input logic [18:0] d);
        logic [18:0] maj_v;
        logic [18:0] xor_v;
        maj_v = (a & b) | (a & d) | (b & d);
        xor_v = a ^ b ^ d;
        return {maj_v[17:0], 1'b0, xor_v};
    endfunction

    logic [37:0] row1_s;
    logic [37:0] row2_s;
    logic [37:0] row3_s;
    logic [37:0] row4_s;

    assign row1_s = csa32(in0, in1, in2);
    assign row2_s = csa32(in3, in4, in5);
    assign row3_s = csa32(row1_s[18:0], row1_s[37:19], row2_s[18:0]);
    assign row4_s = csa32(row3_s[18:0], row3_s[37:19], row2_s[37:19]);
    assign c      = row4_s[37:19];
    assign s      = row4_s[18:0];
endmodule

module csa_accum_ctrl #(
    parameter int MAX_BEATS = 16,
    parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    csa_accum_ctrl_if.slave  bus
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCUM   = 2'd1;
    localparam logic [1:0] ST_RESOLVE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [1:0]        state_r;
    logic [1:0]        state_nx_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  load_cnt_s;
    logic [18:0]       acc_c_r;
    logic [18:0]       acc_s_r;
    logic [18:0]       csa_c_s;
    logic [18:0]       csa_s_s;
    logic [18:0]       sum_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic              busy_r;
    logic              in_hs_s;
    logic              start_acc_s;

    assign in_hs_s     = bus.in_valid & in_ready_r;
    assign start_acc_s = (state_r == ST_IDLE) & bus.start;

    add_16_6 u_csa (
        .in0 (bus.in_data[0]),
        .in1 (bus.in_data[1]),
        .in2 (bus.in_data[2]),
        .in3 (bus.in_data[3]),
        .in4 (acc_c_r),
        .in5 (acc_s_r),
        .c   (csa_c_s),
        .s   (csa_s_s)
    );

    // Clip the requested beat count to MAX_BEATS
    always_comb begin
        load_cnt_s = bus.num_beats;
        if (bus.num_beats > CNT_MAX) begin
            load_cnt_s = CNT_MAX;
        end else begin
            load_cnt_s = bus.num_beats;
        end
    end

    // Next-state decode
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    if (load_cnt_s == CNT_ZERO) begin
                        state_nx_s = ST_RESOLVE;
                    end else begin
                        state_nx_s = ST_ACCUM;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (in_hs_s && (cnt_r == CNT_ONE)) begin
                    state_nx_s = ST_RESOLVE;
                end else begin
                    state_nx_s = ST_ACCUM;
                end
            end
            ST_RESOLVE: begin
                state_nx_s = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State register and flags registered from the next state, so outputs never see inputs combinationally
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            in_ready_r  <= (state_nx_s == ST_ACCUM);
            out_valid_r <= (state_nx_s == ST_DONE);
            busy_r      <= (state_nx_s != ST_IDLE);
        end
    end

    // Redundant accumulator, beat counter and resolved result
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_c_r <= 19'd0;
            acc_s_r <= 19'd0;
            cnt_r   <= CNT_ZERO;
            sum_r   <= 19'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        acc_c_r <= 19'd0;
                        acc_s_r <= 19'd0;
                        cnt_r   <= load_cnt_s;
                    end else begin
                        cnt_r   <= cnt_r;
                    end
                end
                ST_ACCUM: begin
                    if (in_hs_s) begin
                        acc_c_r <= csa_c_s;
                        acc_s_r <= csa_s_s;
                        cnt_r   <= cnt_r - CNT_ONE;
                    end else begin
                        cnt_r   <= cnt_r;
                    end
                end
                ST_RESOLVE: begin
                    sum_r <= acc_c_r + acc_s_r;
                end
                ST_DONE: begin
                    sum_r <= sum_r;
                end
                default: begin
                    cnt_r <= CNT_ZERO;
                end
            endcase
        end
    end

`ifdef CSA_ACCUM_STALL_CNT_EN
    logic [15:0] stall_cnt_r;

    // Saturating count of ACCUM cycles without an offered beat
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= 16'd0;
        end else if (start_acc_s) begin
            stall_cnt_r <= 16'd0;
        end else if ((state_r == ST_ACCUM) && !bus.in_valid && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign bus.stall_cnt = stall_cnt_r;
`else
    logic unused_start_acc_s;
    assign unused_start_acc_s = start_acc_s;
`endif

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_sum   = sum_r;
    assign bus.busy      = busy_r;
endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Randomized self-checking bench for csa_accum_ctrl against a plain-arithmetic sum model.
module tb_csa_accum_ctrl;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [18:0] beats [0:31][0:3];

    csa_accum_ctrl_if #(.MAX_BEATS(16)) bus ();

    csa_accum_ctrl #(.MAX_BEATS(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_beat(input int b, input int v0, input int v1, input int v2, input int v3);
        beats[b][0] = 19'(v0);
        beats[b][1] = 19'(v1);
        beats[b][2] = 19'(v2);
        beats[b][3] = 19'(v3);
    endtask

    task automatic fill_random();
        for (int b = 0; b < 32; b++) begin
            for (int l = 0; l < 4; l++) begin
                beats[b][l] = 19'($urandom);
            end
        end
    endtask

    task automatic drive_noise();
        for (int l = 0; l < 4; l++) begin
            bus.in_data[l] = 19'($urandom);
        end
    endtask

    // gap < 0 selects random gaps of 0..2 idle cycles between beats
    task automatic run_accum(input string tag, input int nb, input int gap, input int hold);
        int nexp;
        int s;
        int cyc;
        int accepted;
        int ready_cyc;
        int stall_exp;
        int gapc;
        int g;
        logic [31:0] exp_sum;
        nexp = (nb > 16) ? 16 : nb;
        s = 0;
        for (int b = 0; b < nexp; b++) begin
            for (int l = 0; l < 4; l++) begin
                s += int'(beats[b][l]);
            end
        end
        exp_sum   = s & 32'h7FFFF;
        accepted  = 0;
        ready_cyc = 0;
        stall_exp = 0;
        gapc      = 0;

        @(negedge clk);
        bus.start     = 1'b1;
        bus.num_beats = 5'(nb);
        @(negedge clk);
        bus.start     = 1'b0;
        cyc = 1;
        while (bus.out_valid !== 1'b1 && cyc < 400) begin
            if (gapc > 0) begin
                bus.in_valid = 1'b0;
                drive_noise();
                gapc--;
            end else begin
                bus.in_valid = 1'b1;
                for (int l = 0; l < 4; l++) begin
                    bus.in_data[l] = beats[(accepted < 32) ? accepted : 31][l];
                end
            end
            if (bus.in_ready === 1'b1) begin
                ready_cyc++;
                if (bus.in_valid) begin
                    accepted++;
                    if (accepted < nexp) begin
                        g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
                        gapc = g;
                        stall_exp += g;
                    end
                end
            end
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
        check_eq({tag, "_latency"}, 32'(cyc), 32'(nexp + 2 + stall_exp));
        check_eq({tag, "_beats"}, 32'(accepted), 32'(nexp));
        check_eq({tag, "_ready_cycles"}, 32'(ready_cyc), 32'(nexp + stall_exp));
        check_eq({tag, "_sum"}, 32'(bus.out_sum), exp_sum);
        check_eq({tag, "_busy"}, 32'(bus.busy), 32'd1);
`ifdef CSA_ACCUM_STALL_CNT_EN
        check_eq({tag, "_stall_cnt"}, 32'(bus.stall_cnt), 32'(stall_exp));
`endif
        // in_valid stays high here and must be ignored; a start pulse in DONE must be ignored too
        for (int h = 0; h < hold; h++) begin
            bus.start = (h == 1);
            bus.num_beats = 5'($urandom_range(0, 20));
            @(negedge clk);
            bus.start = 1'b0;
            check_eq({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            check_eq({tag, "_hold_sum"}, 32'(bus.out_sum), exp_sum);
            check_eq({tag, "_hold_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check_eq({tag, "_post_valid"}, 32'(bus.out_valid), 32'd0);
        check_eq({tag, "_post_busy"}, 32'(bus.busy), 32'd0);
        check_eq({tag, "_post_sum"}, 32'(bus.out_sum), exp_sum);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.num_beats = 5'd0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        for (int l = 0; l < 4; l++) bus.in_data[l] = 19'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_out_sum", 32'(bus.out_sum), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);

        set_beat(0, 1, 2, 3, 4);
        run_accum("basic", 1, 0, 0);

        set_beat(0, 5, 5, 5, 5);
        set_beat(1, 7, 0, 0, 1);
        set_beat(2, 32'h7FFFF, 1, 0, 0);
        run_accum("stalls", 3, 2, 0);

        for (int b = 0; b < 32; b++) set_beat(b, 32'h7FFFF, 32'h7FFFF, 32'h7FFFF, 32'h7FFFF);
        run_accum("wrap", 16, 0, 0);

        run_accum("zero", 0, 0, 0);

        fill_random();
        run_accum("clip", 19, 0, 0);

        fill_random();
        run_accum("backpressure", 4, 1, 5);

        // Abort an accumulation after two of four beats
        fill_random();
        @(negedge clk);
        bus.start     = 1'b1;
        bus.num_beats = 5'd4;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.in_valid  = 1'b1;
        drive_noise();
        @(negedge clk);
        drive_noise();
        @(negedge clk);
        bus.in_valid  = 1'b0;
        reset         = 1'b1;
        @(negedge clk);
        reset         = 1'b0;
        check_eq("abort_in_ready", 32'(bus.in_ready), 32'd0);
        check_eq("abort_busy", 32'(bus.busy), 32'd0);
        check_eq("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("abort_out_sum", 32'(bus.out_sum), 32'd0);
        set_beat(0, 0, 0, 0, 9);
        run_accum("after_abort", 1, 0, 0);

        for (int t = 0; t < 25; t++) begin
            fill_random();
            run_accum("random", int'($urandom_range(0, 20)), -1, int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
